// File: rtl/edge_counter_mc.sv
// Multi-channel gated edge counter: synchronises NCH async inputs and counts selected edges over
// a gate_len-cycle window. Define EDGE_CNT_SYNC3_EN for a 3-flop synchroniser (one extra cycle latency).
`timescale 1ns/1ps
module edge_counter_mc #(
    parameter int NCH    = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 24
) (
    input  logic                 clk,
    input  logic                 async_rst_n,
    input  logic [NCH-1:0]       fin,
    input  logic [1:0]           edge_mode,
    input  logic [GATE_W-1:0]    gate_len,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 abort,
    output logic                 busy,
    output logic                 res_valid,
    output logic [NCH*CNT_W-1:0] cnt_out,
    output logic [NCH-1:0]       ovf
);
    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_RUN    = 1'b1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};
    localparam logic [GATE_W-1:0] GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};

    logic [NCH-1:0]       s1_q, s2_q, s3_q;
    logic [NCH-1:0]       sync_in_s;
    logic [NCH-1:0]       edge_s;
    logic [NCH*CNT_W-1:0] sum_s;
    logic [NCH-1:0]       sat_s;

    logic [0:0]           state_q, state_d;
    logic [GATE_W-1:0]    timer_q, timer_d;
    logic [NCH*CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]       ovfw_q, ovfw_d;
    logic [NCH*CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic [NCH-1:0]       ovf_q, ovf_d;
    logic                 res_valid_q, res_valid_d;
    logic                 busy_q;

    function automatic logic [NCH-1:0] edge_term(input logic [1:0]     mode,
                                                 input logic [NCH-1:0] cur,
                                                 input logic [NCH-1:0] prev);
        case (mode)
            2'b01:   edge_term = ~cur & prev;
            2'b10:   edge_term = cur ^ prev;
            default: edge_term = cur & ~prev;
        endcase
    endfunction

`ifdef EDGE_CNT_SYNC3_EN
    logic [NCH-1:0] s0_q;

    // Extra front synchroniser stage
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            s0_q <= {NCH{1'b0}};
        end else begin
            s0_q <= fin;
        end
    end
    assign sync_in_s = s0_q;
`else
    assign sync_in_s = fin;
`endif

    // Synchroniser tail and edge history flop
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            s1_q <= {NCH{1'b0}};
            s2_q <= {NCH{1'b0}};
            s3_q <= {NCH{1'b0}};
        end else begin
            s1_q <= sync_in_s;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_s = edge_term(edge_mode, s2_q, s3_q);

    // Per-channel saturating add; a saturated channel keeps its count and flags overflow
    always_comb begin
        sum_s = cnt_q;
        sat_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (edge_s[i] && (cnt_q[i*CNT_W +: CNT_W] == CNT_MAX)) begin
                sat_s[i] = 1'b1;
            end else begin
                sum_s[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(edge_s[i]);
            end
        end
    end

    // Window FSM: abort beats window end; the last cycle's edge goes into the latched result
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        ovfw_d      = ovfw_q;
        cnt_out_d   = cnt_out_q;
        ovf_d       = ovf_q;
        res_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (gate_len != GATE_ZERO)) begin
                    state_d = ST_RUN;
                    timer_d = gate_len - GATE_ONE;
                    cnt_d   = {(NCH*CNT_W){1'b0}};
                    ovfw_d  = {NCH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    timer_d = GATE_ZERO;
                    cnt_d   = {(NCH*CNT_W){1'b0}};
                    ovfw_d  = {NCH{1'b0}};
                end else if (timer_q == GATE_ZERO) begin
                    cnt_out_d   = sum_s;
                    ovf_d       = ovfw_q | sat_s;
                    res_valid_d = 1'b1;
                    cnt_d       = {(NCH*CNT_W){1'b0}};
                    ovfw_d      = {NCH{1'b0}};
                    if (continuous && (gate_len != GATE_ZERO)) begin
                        timer_d = gate_len - GATE_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d   = sum_s;
                    ovfw_d  = ovfw_q | sat_s;
                    timer_d = timer_q - GATE_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = GATE_ZERO;
                cnt_d   = {(NCH*CNT_W){1'b0}};
                ovfw_d  = {NCH{1'b0}};
            end
        endcase
    end

    // State, live counters and registered outputs
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= GATE_ZERO;
            cnt_q       <= {(NCH*CNT_W){1'b0}};
            ovfw_q      <= {NCH{1'b0}};
            cnt_out_q   <= {(NCH*CNT_W){1'b0}};
            ovf_q       <= {NCH{1'b0}};
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            ovfw_q      <= ovfw_d;
            cnt_out_q   <= cnt_out_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            busy_q      <= (state_d == ST_RUN);
        end
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign cnt_out   = cnt_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_counter_mc.sv
// Scoreboard bench for edge_counter_mc: a 16-bit and a 4-bit instance share one stimulus stream.
`timescale 1ns/1ps
module tb_edge_counter_mc;
    localparam int NCH  = 4;
    localparam int GW   = 24;
    localparam int WMAX = 65535;
    localparam int NMAX = 15;

    typedef struct packed {
        logic [NCH-1:0][31:0] cnt;
        logic                 busy_after;
        logic [31:0]          exp_cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            async_rst_n = 1'b1;
    logic [NCH-1:0]  fin = '0;
    logic [1:0]      edge_mode = 2'b00;
    logic [GW-1:0]   gate_len = '0;
    logic            start = 1'b0;
    logic            continuous = 1'b0;
    logic            abort = 1'b0;
    logic            busy, res_valid;
    logic [NCH*16-1:0] cnt_out;
    logic [NCH-1:0]  ovf;
    logic            busy4, res_valid4;
    logic [NCH*4-1:0] cnt_out4;
    logic [NCH-1:0]  ovf4;

    int   n_total = 0;
    int   n_bad   = 0;
    int   n_res   = 0;
    int   cyc     = 0;
    int   sum2    = 0;
    exp_t sb_q[$];
    exp_t last_e = '0;

    edge_counter_mc #(.NCH(NCH), .CNT_W(16), .GATE_W(GW)) u_dut (
        .clk(clk), .async_rst_n(async_rst_n), .fin(fin), .edge_mode(edge_mode),
        .gate_len(gate_len), .start(start), .continuous(continuous), .abort(abort),
        .busy(busy), .res_valid(res_valid), .cnt_out(cnt_out), .ovf(ovf));

    edge_counter_mc #(.NCH(NCH), .CNT_W(4), .GATE_W(GW)) u_dut4 (
        .clk(clk), .async_rst_n(async_rst_n), .fin(fin), .edge_mode(edge_mode),
        .gate_len(gate_len), .start(start), .continuous(continuous), .abort(abort),
        .busy(busy4), .res_valid(res_valid4), .cnt_out(cnt_out4), .ovf(ovf4));

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int sat_to(input int c, input int maxv);
        return (c > maxv) ? maxv : c;
    endfunction

    function automatic int count_edges(input logic lvl, input int ntog, input logic [1:0] mode);
        int r = 0;
        int f = 0;
        logic l = lvl;
        for (int k = 0; k < ntog; k++) begin
            l = ~l;
            if (l) r++; else f++;
        end
        case (mode)
            2'b01:   return f;
            2'b10:   return r + f;
            default: return r;
        endcase
    endfunction

    task automatic toggle(input int ch, input int ntog, input int gap);
        for (int k = 0; k < ntog; k++) begin
            fin[ch] = ~fin[ch];
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_res(input int target, input int budget, input string tag);
        int k = 0;
        while ((n_res < target) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_result_seen"}, n_res >= target, 1'b1);
    endtask

    // Result monitor: pops one expectation per res_valid and checks both instances
    initial begin
        exp_t e;
        int   c;
        forever begin
            @(negedge clk);
            if (async_rst_n && (res_valid || res_valid4)) begin
                n_res++;
                chk("rv_pair", res_valid4, res_valid);
                chk("rv_expected", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("rv_cycle", cyc, e.exp_cyc);
                    chk("busy_at_rv", busy, e.busy_after);
                    for (int ch = 0; ch < NCH; ch++) begin
                        c = int'(e.cnt[ch]);
                        chk($sformatf("w_cnt%0d", ch), cnt_out[ch*16 +: 16], sat_to(c, WMAX));
                        chk($sformatf("w_ovf%0d", ch), ovf[ch], c > WMAX);
                        chk($sformatf("n_cnt%0d", ch), cnt_out4[ch*4 +: 4], sat_to(c, NMAX));
                        chk($sformatf("n_ovf%0d", ch), ovf4[ch], c > NMAX);
                    end
                    sum2 += int'(cnt_out[2*16 +: 16]);
                    last_e = e;
                end
            end
        end
    end

    task automatic shot(input string tag, input int gl, input logic [1:0] mode,
                        input int ch, input int ntog, input int gap, input int lead);
        exp_t e = '0;
        int   res0 = n_res;
        e.cnt[ch]     = count_edges(fin[ch], ntog, mode);
        e.busy_after  = 1'b0;
        gate_len      = GW'(gl);
        edge_mode     = mode;
        continuous    = 1'b0;
        start         = 1'b1;
        e.exp_cyc     = cyc + 1 + gl;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1'b1);
        repeat (lead) @(negedge clk);
        toggle(ch, ntog, gap);
        wait_res(res0 + 1, gl + 50, tag);
        @(negedge clk);
        chk({tag, "_busy_low"}, busy, 1'b0);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        int res0;
        exp_t e;
        // Reset with fin activity
        async_rst_n = 1'b0;
        fin[3] = 1'b1;
        #5;
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", cnt_out, 64'd0);
        chk("rst_ovf4", ovf4, 4'd0);
        #2;
        async_rst_n = 1'b1;
        fin[3] = 1'b0;
        toggle(3, 10, 2);
        chk("idle_busy", busy, 1'b0);
        chk("idle_rv", res_valid, 1'b0);
        chk("idle_cnt", cnt_out, 64'd0);
        chk("idle_cnt4", cnt_out4, 16'd0);
        chk("idle_ovf", ovf, 4'd0);
        chk("idle_nres", n_res, 0);

        // Single-shot windows on channel 0 in each edge mode
        shot("rise", 2000, 2'b00, 0, 200, 9, 20);
        shot("both", 2000, 2'b10, 0, 200, 9, 20);
        shot("fall", 2000, 2'b01, 0, 200, 9, 20);
        shot("rise11", 2000, 2'b11, 0, 200, 9, 20);

        // Saturation of the 4-bit instance on channel 1
        shot("sat", 40, 2'b10, 1, 16, 2, 2);

        // Continuous back-to-back windows, channel 2 rising every 10 clk
        sum2 = 0;
        res0 = n_res;
        gate_len   = GW'(1000);
        edge_mode  = 2'b00;
        continuous = 1'b1;
        fork
            toggle(2, 1020, 5);
            begin
                repeat (20) @(negedge clk);
                start = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    e = '0;
                    e.cnt[2]     = 100;
                    e.busy_after = (k < 4);
                    e.exp_cyc    = cyc + 1 + 1000 * (k + 1);
                    sb_q.push_back(e);
                end
                @(negedge clk);
                start = 1'b0;
                wait_res(res0 + 4, 4100, "cont4");
                repeat (10) @(negedge clk);
                continuous = 1'b0;
                wait_res(res0 + 5, 1100, "cont5");
            end
        join
        chk("cont_sum", sum2, 500);
        chk("cont_busy_low", busy, 1'b0);

        // Abort mid-window: no result, latched outputs untouched
        res0 = n_res;
        gate_len = GW'(1000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        toggle(3, 40, 5);
        repeat (300) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        repeat (1200) @(negedge clk);
        chk("abort_nres", n_res, res0);
        for (int ch = 0; ch < NCH; ch++) begin
            chk($sformatf("abort_w_cnt%0d", ch), cnt_out[ch*16 +: 16], sat_to(int'(last_e.cnt[ch]), WMAX));
            chk($sformatf("abort_n_ovf%0d", ch), ovf4[ch], int'(last_e.cnt[ch]) > NMAX);
        end

        // Start with zero gate length is ignored
        gate_len = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("gl0_busy", busy, 1'b0);
        repeat (50) @(negedge clk);
        chk("gl0_busy_late", busy, 1'b0);
        chk("gl0_nres", n_res, res0);
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
